chan_pkt_framer: RTL

//  Downstream of the per-channel word counter. Captures accepted channel words
//  (data_valid) into a local buffer while chan_cmpl is low. On the channel-end

---
 rtl/chan_pkt_framer_if.sv | 13 +
 rtl/chan_pkt_framer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/chan_pkt_framer_if.sv
// Packet output stream of chan_pkt_framer: valid/ready word stream with sop/eop markers.
interface chan_pkt_framer_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] pkt_data;
  logic              pkt_valid;
  logic              pkt_rdy;
  logic              pkt_sop;
  logic              pkt_eop;

  modport master (output pkt_data, pkt_valid, pkt_sop, pkt_eop, input pkt_rdy);
  modport slave  (input pkt_data, pkt_valid, pkt_sop, pkt_eop, output pkt_rdy);
endinterface

// File: rtl/chan_pkt_framer.sv
// Buffers one channel's words and emits them as a header-led packet.
// Define CHAN_PKT_CSUM_EN to append a modulo-2^DATA_W checksum tail word.
module chan_pkt_framer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk20,
  input  logic              res,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              chan_cmpl,
  input  logic [3:0]        chan_id,
  chan_pkt_framer_if.master pkt,
  output logic              ovf,
  output logic              busy_drop
);
  localparam int unsigned   CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
`ifdef CHAN_PKT_CSUM_EN
  localparam logic DATA_EOP = 1'b0;
`else
  localparam logic DATA_EOP = 1'b1;
`endif

  typedef enum logic [2:0] {
    IDLE, COLLECT, HDR, DATA
`ifdef CHAN_PKT_CSUM_EN
    , TAIL
`endif
  } state_t;

  state_t            state;
  logic              chan_cmpl_d;
  logic [3:0]        id_q;
  logic [CW-1:0]     count;
  logic [CW-1:0]     left;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              sop_q;
  logic              eop_q;
  logic [DATA_W-1:0] mem [DEPTH];
`ifdef CHAN_PKT_CSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  logic              fall, rise, start, full, xfer, wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] header;

  assign fall    = chan_cmpl_d & ~chan_cmpl;
  assign rise    = ~chan_cmpl_d & chan_cmpl;
  assign start   = fall & ((state == IDLE) | (state == COLLECT));
  assign full    = (count == FULL);
  assign xfer    = valid_q & pkt.pkt_rdy;
  // A word arriving on the start cycle itself lands at address 0.
  assign wr_en   = data_valid & (start | ((state == COLLECT) & ~full & ~rise));
  assign wr_addr = start ? '0 : wr_ptr;
  assign header  = {id_q, {(DATA_W-12){1'b0}}, count[7:0]};

  assign pkt.pkt_data  = data_q;
  assign pkt.pkt_valid = valid_q;
  assign pkt.pkt_sop   = sop_q;
  assign pkt.pkt_eop   = eop_q;

  always_ff @(posedge clk20) begin
    if (wr_en) mem[wr_addr] <= data_in;
  end

  always_ff @(posedge clk20 or posedge res) begin
    if (res) begin
      state       <= IDLE;
      chan_cmpl_d <= 1'b1;
      id_q        <= '0;
      count       <= '0;
      left        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      ovf         <= 1'b0;
      busy_drop   <= 1'b0;
`ifdef CHAN_PKT_CSUM_EN
      csum        <= '0;
`endif
    end else begin
      chan_cmpl_d <= chan_cmpl;
      busy_drop   <= fall & ~start;
      case (state)
        IDLE, COLLECT: begin
          if (start) begin
            state  <= COLLECT;
            id_q   <= chan_id;
            ovf    <= 1'b0;
            count  <= data_valid ? CW'(1) : '0;
            wr_ptr <= data_valid ? AW'(1) : '0;
            rd_ptr <= '0;
          end else if (state == COLLECT) begin
            if (rise) begin
              state <= HDR;
            end else if (data_valid) begin
              if (full) begin
                ovf <= 1'b1;
              end else begin
                wr_ptr <= wr_ptr + AW'(1);
                count  <= count + CW'(1);
              end
            end
          end
        end
        HDR: begin
          // First HDR cycle loads the header; the buffer read for word 0 follows on transfer.
          if (!valid_q) begin
            valid_q <= 1'b1;
            sop_q   <= 1'b1;
            data_q  <= header;
            eop_q   <= DATA_EOP & (count == '0);
`ifdef CHAN_PKT_CSUM_EN
            csum    <= '0;
`endif
          end else if (xfer) begin
            sop_q <= 1'b0;
`ifdef CHAN_PKT_CSUM_EN
            csum  <= csum + data_q;
`endif
            if (count == '0) begin
`ifdef CHAN_PKT_CSUM_EN
              state  <= TAIL;
              data_q <= csum + data_q;
              eop_q  <= 1'b1;
`else
              state   <= IDLE;
              valid_q <= 1'b0;
              eop_q   <= 1'b0;
`endif
            end else begin
              state  <= DATA;
              data_q <= mem[rd_ptr];
              rd_ptr <= rd_ptr + AW'(1);
              left   <= count - CW'(1);
              eop_q  <= DATA_EOP & (count == CW'(1));
            end
          end
        end
        DATA: begin
          if (xfer) begin
`ifdef CHAN_PKT_CSUM_EN
            csum <= csum + data_q;
`endif
            if (left == '0) begin
`ifdef CHAN_PKT_CSUM_EN
              state  <= TAIL;
              data_q <= csum + data_q;
              eop_q  <= 1'b1;
`else
              state   <= IDLE;
              valid_q <= 1'b0;
              eop_q   <= 1'b0;
`endif
            end else begin
              data_q <= mem[rd_ptr];
              rd_ptr <= rd_ptr + AW'(1);
              left   <= left - CW'(1);
              eop_q  <= DATA_EOP & (left == CW'(1));
            end
          end
        end
`ifdef CHAN_PKT_CSUM_EN
        TAIL: begin
          if (xfer) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            eop_q   <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule
